// File: rtl/cve2_pkg.sv
// cve2_pkg: shared encodings for the hardware-loop register file and PC select.
package cve2_pkg;
  typedef enum logic [2:0] {
    HWLP_START0 = 3'd0,
    HWLP_END0   = 3'd1,
    HWLP_CNT0   = 3'd2,
    HWLP_START1 = 3'd3,
    HWLP_END1   = 3'd4,
    HWLP_CNT1   = 3'd5
  } hwlp_reg_e;
  typedef enum logic [2:0] {
    PC_BOOT,
    PC_JUMP,
    PC_EXC,
    PC_ERET,
    PC_DRET,
    PC_BP,
    PC_HWLP0,
    PC_HWLP1
  } pc_sel_e;
endpackage

// File: rtl/cve2_hwloop_ctx.sv
// cve2_hwloop_ctx: one loop context (start/end/count) with end-PC match and write-wins saturating decrement.
module cve2_hwloop_ctx #(
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_start,
  input  logic                we_end,
  input  logic                we_cnt,
  input  logic [31:0]         wdata,
  input  logic [31:0]         pc,
  input  logic                retire,
  input  logic                dec,
  output logic [31:0]         start,
  output logic [CntWidth-1:0] cnt,
  output logic                match,
  output logic                last
);
  logic [31:0] end_addr;
  assign match = retire && pc == end_addr && cnt != '0;
  assign last  = cnt == CntWidth'(1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      start    <= '0;
      end_addr <= '0;
      cnt      <= '0;
    end else begin
      if (we_start) start <= wdata & ~32'h1;
      if (we_end) end_addr <= wdata & ~32'h1;
      if (we_cnt) cnt <= wdata[CntWidth-1:0];
      else if (dec && cnt != '0) cnt <= cnt - CntWidth'(1);
    end
endmodule

// File: rtl/cve2_hwloop_controller.sv
// cve2_hwloop_controller: zero-overhead loop sequencer; loop 1 (outer) exists only with CVE2_HWLP_NESTED_EN.
module cve2_hwloop_controller
  import cve2_pkg::*;
#(
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [2:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         pc_id_i,
  input  logic                instr_valid_id_i,
  input  logic                instr_retire_i,
  input  logic                ext_pc_set_i,
  output logic                hwlp_jump_o,
  output logic                hwlp_sel_o,
  output logic [31:0]         hwlp0_start_o,
  output logic [31:0]         hwlp1_start_o,
  output logic [1:0]          hwlp_active_o,
  output logic [CntWidth-1:0] hwlp0_cnt_o,
  output logic [CntWidth-1:0] hwlp1_cnt_o
);
  logic go, m0, l0;
  assign go = instr_valid_id_i & instr_retire_i & ~ext_pc_set_i;
  cve2_hwloop_ctx #(.CntWidth(CntWidth)) u_ctx0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_start (we_i && waddr_i == HWLP_START0),
    .we_end   (we_i && waddr_i == HWLP_END0),
    .we_cnt   (we_i && waddr_i == HWLP_CNT0),
    .wdata    (wdata_i),
    .pc       (pc_id_i),
    .retire   (go),
    .dec      (m0),
    .start    (hwlp0_start_o),
    .cnt      (hwlp0_cnt_o),
    .match    (m0),
    .last     (l0)
  );
`ifdef CVE2_HWLP_NESTED_EN
  logic m1, l1;
  // inner loop 0 wins a shared end PC; loop 1 is left untouched that cycle
  cve2_hwloop_ctx #(.CntWidth(CntWidth)) u_ctx1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_start (we_i && waddr_i == HWLP_START1),
    .we_end   (we_i && waddr_i == HWLP_END1),
    .we_cnt   (we_i && waddr_i == HWLP_CNT1),
    .wdata    (wdata_i),
    .pc       (pc_id_i),
    .retire   (go),
    .dec      (m1 & ~m0),
    .start    (hwlp1_start_o),
    .cnt      (hwlp1_cnt_o),
    .match    (m1),
    .last     (l1)
  );
  assign hwlp_sel_o    = m1 & ~m0;
  assign hwlp_jump_o   = m0 ? ~l0 : (m1 & ~l1);
  assign hwlp_active_o = {hwlp1_cnt_o != '0, hwlp0_cnt_o != '0};
`else
  assign hwlp1_start_o = '0;
  assign hwlp1_cnt_o   = '0;
  assign hwlp_sel_o    = 1'b0;
  assign hwlp_jump_o   = m0 & ~l0;
  assign hwlp_active_o = {1'b0, hwlp0_cnt_o != '0};
`endif
endmodule

// File: doc/cve2_hwloop_controller.md
Name: cve2_hwloop_controller

Overview:
Sequences zero-overhead hardware loops for the fetch stage. It holds up to two loop contexts (start, end, count). When the instruction at a loop's end address retires, it requests a PC redirect to that loop's start. It drives the IF stage's `hwlp0_start_i`/`hwlp1_start_i`, and feeds the controller's `pc_set`/`pc_mux` path with `PC_HWLP0`/`PC_HWLP1` requests. It sits beside the ID-stage controller and is written by the lp.setup/lp.count decode path.

Parameters:
- CntWidth, 32, width of each loop iteration counter (minimum 2).

Ports:
- `clk_i` in 1: clock; the block has one clock.
- `rst_i` in 1: reset, asynchronous and active-high; clears all state.
- `we_i` in 1: loop register write strobe.
- `waddr_i` in 3: target register, `hwlp_reg_e` encoding.
- `wdata_i` in 32: write data.
- `pc_id_i` in 32: PC of the instruction in ID.
- `instr_valid_id_i` in 1: ID instruction valid.
- `instr_retire_i` in 1: ID instruction completes this cycle.
- `ext_pc_set_i` in 1: branch, jump, exception or debug redirect this cycle.
- `hwlp_jump_o` out 1: request PC redirect to a loop start.
- `hwlp_sel_o` out 1: 0 selects `PC_HWLP0`, 1 selects `PC_HWLP1`.
- `hwlp0_start_o` out 32: loop 0 start address.
- `hwlp1_start_o` out 32: loop 1 start address.
- `hwlp_active_o` out 2: per-loop count != 0.
- `hwlp0_cnt_o` out CntWidth: loop 0 remaining count.
- `hwlp1_cnt_o` out CntWidth: loop 1 remaining count.

Behaviour:
- Reset:
  - All start/end/count registers are 0.
  - Outputs: `hwlp_jump_o`=0, `hwlp_sel_o`=0, starts=0, `hwlp_active_o`=2'b00, counts=0.
  - Reset asserted mid-loop abandons the loop immediately, with no further jump.
- Per-loop state is derived from the count register:
  - IDLE: cnt==0.
  - RUN: cnt>=2.
  - LAST: cnt==1.
- Loop k matches when all of the following hold:
  - `instr_valid_id_i` & `instr_retire_i` & ~`ext_pc_set_i`;
  - `pc_id_i` == end_k;
  - loop k is not IDLE.
- On a match in RUN:
  - `hwlp_jump_o`=1 combinationally in the same cycle, `hwlp_sel_o`=k.
  - cnt_k decrements at the next edge.
- On a match in LAST:
  - No jump; the loop falls through.
  - cnt_k -> 0 at the next edge (transition to IDLE).
- Nesting: loop 0 is the inner loop and has priority.
  - If both loops match in the same cycle, only loop 0 acts (jump or fall-through).
  - Loop 1 is untouched that cycle.
- `ext_pc_set_i`=1 suppresses any jump and any decrement that cycle. Counts are preserved, so an exception inside the body resumes correctly after mret.
- Writes take effect at the next edge:
  - start/end: bit 0 is forced to 0.
  - count: the low CntWidth bits of `wdata_i` are taken.
- A write to cnt_k in the same cycle as a decrement of cnt_k: the write wins, with no decrement.
- A write to end_k or start_k in the same cycle as a match uses the old values for that cycle.
- Writing count=0 deactivates the loop immediately from the next cycle.
- A counter never wraps: decrement occurs only from a value >= 1.
- Unmapped `waddr_i` values (6, 7) are ignored.
- The jump request is only valid together with retire. The consumer (ID controller) asserts `pc_set` with `pc_mux` = `PC_HWLP0`/`PC_HWLP1` in that cycle.

Optional Feature:
- Macro `CVE2_HWLP_NESTED_EN`.
- Defined: both loop contexts exist, and the nesting priority above applies.
- Undefined:
  - Only loop 0 is implemented.
  - Writes to loop-1 registers are ignored.
  - `hwlp1_start_o`=0, `hwlp1_cnt_o`=0, `hwlp_active_o[1]`=0, `hwlp_sel_o` tied 0.

Decomposition:
- `cve2_pkg` additions:
  - `hwlp_reg_e` (3-bit): HWLP_START0=0, HWLP_END0=1, HWLP_CNT0=2, HWLP_START1=3, HWLP_END1=4, HWLP_CNT1=5.
  - The existing `pc_sel_e` PC_HWLP0/PC_HWLP1 values are reused.
- Sub-module `cve2_hwloop_ctx`:
  - One instance per loop.
  - Holds start/end/cnt, the write logic, the match comparator, and saturating decrement with write-wins.
- The top level does the priority resolution and the output muxing.

Test Plan:
- **Basic loop:** write start0=0x100, end0=0x10C, cnt0=3; retire PC 0x10C three times -> jump with sel=0 on the 1st and 2nd retire; no jump on the 3rd; cnt0 ends at 0; `hwlp_active_o`=00.
- **Nested loops:** loop1 0x200–0x220 cnt=2, loop0 0x204–0x210 cnt=2; run to completion -> 0x210 jumps once per outer iteration; 0x220 jumps once; total retires at 0x210 = 4; both counts end at 0.
- **Shared end PC:** end0=end1=0x300, cnt0=1, cnt1=5; retire 0x300 -> no jump; cnt0=0; cnt1 stays 5. Next retire at 0x300 -> jump with sel=1; cnt1=4.
- **Redirect suppression:** cnt0=4 with a match at end0 and `ext_pc_set_i`=1 -> `hwlp_jump_o`=0; cnt0 stays 4.
- **Write-vs-decrement:** write cnt0=7 in the same cycle as a matching retire with cnt0=2 -> jump asserted; cnt0=7 next cycle.
- **Reset mid-loop:** `rst_i` pulsed asynchronously while cnt0=5 -> all outputs 0 immediately; a following retire at the old end PC does not jump. With `CVE2_HWLP_NESTED_EN` undefined, writes to HWLP_CNT1 leave `hwlp1_cnt_o`=0.
